order_book_engine: RTL and testbench

Parametrised multi-stock limit order book: accepts ADD/CANCEL/EXECUTE commands over a valid/ready handshake and stores resting orders per stock and side. After each command it rescans the affected stock's book to publish best bid, best ask and last traded price. It sits between the ITCH-style message decoder and the trading logic. Behaviour not present in the previous book: side handling, per-command status, execute partial fills, a per-stock best-price cache, and a flow-controlled input.

---
 rtl/order_book_pkg.sv | 27 ++
 rtl/order_book_engine_if.sv | 45 ++++
 rtl/order_slot_match.sv | 34 +++
 rtl/order_book_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_order_book_engine.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/order_book_pkg.sv
// Shared types for the limit order book engine: command and status
// encodings, side constants and the engine FSM state.
package order_book_pkg;

    typedef enum logic [1:0] {
        ORD_ADD     = 2'd0,
        ORD_CANCEL  = 2'd1,
        ORD_EXECUTE = 2'd2,
        ORD_RSVD    = 2'd3
    } order_t;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_FULL      = 3'd1,
        ST_NOT_FOUND = 3'd2,
        ST_DUP_ID    = 3'd3,
        ST_BAD_CMD   = 3'd4
    } status_t;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_MATCH, S_UPDATE, S_SCAN, S_PUBLISH
    } state_t;

endpackage

// File: rtl/order_book_engine_if.sv
// Command/result bundle between the message decoder (master) and the
// order book engine (slave): valid/ready command in, result fields out.
interface order_book_engine_if
    import order_book_pkg::*;
#(
    parameter int NUM_STOCKS = 4,
    parameter int PRICE_W    = 32,
    parameter int QTY_W      = 16,
    parameter int ID_W       = 32,
    parameter int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
);
    logic               i_valid;
    logic               o_ready;
    logic [SID_W-1:0]   i_stock_id;
    logic [1:0]         i_order_type;
    logic               i_side;
    logic [QTY_W-1:0]   i_quantity;
    logic [PRICE_W-1:0] i_price;
    logic [ID_W-1:0]    i_order_id;
    logic               o_data_valid;
    logic [SID_W-1:0]   o_stock_id;
    status_t            o_status;
    logic [PRICE_W-1:0] o_best_bid;
    logic               o_bid_valid;
    logic [PRICE_W-1:0] o_best_ask;
    logic               o_ask_valid;
    logic [PRICE_W-1:0] o_last_price;
    logic [QTY_W-1:0]   o_exec_qty;

    modport master (
        output i_valid, i_stock_id, i_order_type, i_side,
        output i_quantity, i_price, i_order_id,
        input  o_ready, o_data_valid, o_stock_id, o_status,
        input  o_best_bid, o_bid_valid, o_best_ask, o_ask_valid,
        input  o_last_price, o_exec_qty
    );

    modport slave (
        input  i_valid, i_stock_id, i_order_type, i_side,
        input  i_quantity, i_price, i_order_id,
        output o_ready, o_data_valid, o_stock_id, o_status,
        output o_best_bid, o_bid_valid, o_best_ask, o_ask_valid,
        output o_last_price, o_exec_qty
    );
endinterface

// File: rtl/order_slot_match.sv
// Combinational slot search over one stock's book: lowest-index free slot
// and lowest-index live slot whose id matches. Ports: slot valid bits and
// ids in, target id in; found flags and indices out.
module order_slot_match #(
    parameter int BOOK_DEPTH = 16,
    parameter int ID_W       = 32,
    parameter int IDX_W      = (BOOK_DEPTH > 1) ? $clog2(BOOK_DEPTH) : 1
) (
    input  logic [BOOK_DEPTH-1:0] i_valid,
    input  logic [ID_W-1:0]       i_ids [BOOK_DEPTH],
    input  logic [ID_W-1:0]       i_id,
    output logic                  o_free_found,
    output logic [IDX_W-1:0]      o_free_idx,
    output logic                  o_id_found,
    output logic [IDX_W-1:0]      o_id_idx
);
    // Walk high to low so the lowest matching index is written last.
    always_comb begin
        o_free_found = 1'b0;
        o_free_idx   = '0;
        o_id_found   = 1'b0;
        o_id_idx     = '0;
        for (int i = BOOK_DEPTH - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_free_found = 1'b1;
                o_free_idx   = IDX_W'(i);
            end
            if (i_valid[i] && (i_ids[i] == i_id)) begin
                o_id_found = 1'b1;
                o_id_idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/order_book_engine.sv
// Multi-stock limit order book: ADD/CANCEL/EXECUTE over valid/ready, then a
// per-slot rescan refreshes the stock's best bid/ask cache and publishes it.
// Ports: i_clk, i_reset (async, active high), bus (slave side of the bundle).
module order_book_engine
    import order_book_pkg::*;
#(
    parameter int NUM_STOCKS = 4,
    parameter int BOOK_DEPTH = 16,
    parameter int PRICE_W    = 32,
    parameter int QTY_W      = 16,
    parameter int ID_W       = 32,
    parameter int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input logic                i_clk,
    input logic                i_reset,
    order_book_engine_if.slave bus
);
    localparam int IDX_W = (BOOK_DEPTH > 1) ? $clog2(BOOK_DEPTH) : 1;

    typedef struct packed {
        logic               valid;
        logic               side;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
        logic [ID_W-1:0]    id;
    } slot_t;

    typedef struct packed {
        logic [PRICE_W-1:0] best_bid;
        logic               bid_valid;
        logic [PRICE_W-1:0] best_ask;
        logic               ask_valid;
        logic [PRICE_W-1:0] last_price;
    } cache_t;

    typedef struct packed {
        logic [SID_W-1:0]   stock;
        order_t             otype;
        logic               side;
        logic [QTY_W-1:0]   qty;
        logic [PRICE_W-1:0] price;
        logic [ID_W-1:0]    id;
    } cmd_t;

    typedef struct packed {
        logic [SID_W-1:0] stock;
        status_t          status;
        cache_t           cache;
        logic [QTY_W-1:0] exec_qty;
    } res_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    slot_t            book_q [NUM_STOCKS][BOOK_DEPTH];
    slot_t            book_d [NUM_STOCKS][BOOK_DEPTH];
    cache_t           cache_q [NUM_STOCKS];
    cache_t           cache_d [NUM_STOCKS];
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic [IDX_W-1:0] id_idx_q, id_idx_d;
    status_t          status_q, status_d;
    logic [QTY_W-1:0] fill_q, fill_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    cache_t           scan_q, scan_d;
    res_t             res_q, res_d;

    logic [BOOK_DEPTH-1:0] m_valid;
    logic [ID_W-1:0]       m_ids [BOOK_DEPTH];
    logic                  free_found, id_found;
    logic [IDX_W-1:0]      free_idx, id_idx;

    always_comb begin
        for (int i = 0; i < BOOK_DEPTH; i++) begin
            m_valid[i] = book_q[cmd_q.stock][i].valid;
            m_ids[i]   = book_q[cmd_q.stock][i].id;
        end
    end

    order_slot_match #(
        .BOOK_DEPTH (BOOK_DEPTH),
        .ID_W       (ID_W),
        .IDX_W      (IDX_W)
    ) u_match (
        .i_valid      (m_valid),
        .i_ids        (m_ids),
        .i_id         (cmd_q.id),
        .o_free_found (free_found),
        .o_free_idx   (free_idx),
        .o_id_found   (id_found),
        .o_id_idx     (id_idx)
    );

    slot_t            cur;
    logic [QTY_W-1:0] fill;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        book_d     = book_q;
        cache_d    = cache_q;
        free_idx_d = free_idx_q;
        id_idx_d   = id_idx_q;
        status_d   = status_q;
        fill_d     = fill_q;
        scan_idx_d = scan_idx_q;
        scan_d     = scan_q;
        res_d      = res_q;
        cur        = '0;
        fill       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    cmd_d.stock = bus.i_stock_id;
                    cmd_d.otype = order_t'(bus.i_order_type);
                    cmd_d.side  = bus.i_side;
                    cmd_d.qty   = bus.i_quantity;
                    cmd_d.price = bus.i_price;
                    cmd_d.id    = bus.i_order_id;
                    state_d     = S_MATCH;
                end
            end
            S_MATCH: begin
                free_idx_d = free_idx;
                id_idx_d   = id_idx;
                status_d   = ST_OK;
                if (cmd_q.otype == ORD_RSVD || cmd_q.qty == '0)
                    status_d = ST_BAD_CMD;
                else if (cmd_q.otype == ORD_ADD && id_found)
                    status_d = ST_DUP_ID;
                else if (cmd_q.otype == ORD_ADD && !free_found)
                    status_d = ST_FULL;
                else if (cmd_q.otype != ORD_ADD && !id_found)
                    status_d = ST_NOT_FOUND;
                state_d = (status_d == ST_OK) ? S_UPDATE : S_PUBLISH;
            end
            S_UPDATE: begin
                fill_d = '0;
                cur    = book_q[cmd_q.stock][id_idx_q];
                unique case (cmd_q.otype)
                    ORD_ADD: begin
                        book_d[cmd_q.stock][free_idx_q] = '{valid: 1'b1,
                            side: cmd_q.side, price: cmd_q.price,
                            qty: cmd_q.qty, id: cmd_q.id};
                    end
                    ORD_CANCEL: book_d[cmd_q.stock][id_idx_q].valid = 1'b0;
                    ORD_EXECUTE: begin
                        fill = (cmd_q.qty < cur.qty) ? cmd_q.qty : cur.qty;
                        book_d[cmd_q.stock][id_idx_q].qty = cur.qty - fill;
                        if (cur.qty == fill)
                            book_d[cmd_q.stock][id_idx_q].valid = 1'b0;
                        cache_d[cmd_q.stock].last_price = cur.price;
                        fill_d = fill;
                    end
                    default: ;
                endcase
                scan_idx_d = '0;
                scan_d     = '{best_bid: '0, bid_valid: 1'b0,
                               best_ask: '1, ask_valid: 1'b0,
                               last_price: '0};
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                cur = book_q[cmd_q.stock][scan_idx_q];
                // Strict compares: an equal price leaves the best unchanged.
                if (cur.valid && cur.side == SIDE_BUY &&
                    (!scan_q.bid_valid || cur.price > scan_q.best_bid)) begin
                    scan_d.best_bid  = cur.price;
                    scan_d.bid_valid = 1'b1;
                end
                if (cur.valid && cur.side == SIDE_SELL &&
                    (!scan_q.ask_valid || cur.price < scan_q.best_ask)) begin
                    scan_d.best_ask  = cur.price;
                    scan_d.ask_valid = 1'b1;
                end
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_W'(BOOK_DEPTH - 1)) begin
                    cache_d[cmd_q.stock].best_bid  = scan_d.best_bid;
                    cache_d[cmd_q.stock].bid_valid = scan_d.bid_valid;
                    cache_d[cmd_q.stock].best_ask  = scan_d.best_ask;
                    cache_d[cmd_q.stock].ask_valid = scan_d.ask_valid;
                    state_d = S_PUBLISH;
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Result registers load on entry to PUBLISH so they are valid
        // during the o_data_valid cycle and hold until the next publish.
        if (state_d == S_PUBLISH && state_q != S_PUBLISH) begin
            res_d.stock    = cmd_q.stock;
            res_d.status   = status_d;
            res_d.cache    = cache_d[cmd_q.stock];
            res_d.exec_qty = (status_d == ST_OK &&
                              cmd_q.otype == ORD_EXECUTE) ? fill_d : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            free_idx_q <= '0;
            id_idx_q   <= '0;
            status_q   <= ST_OK;
            fill_q     <= '0;
            scan_idx_q <= '0;
            scan_q     <= '0;
            res_q      <= '{stock: '0, status: ST_OK,
                            cache: '{best_bid: '0, bid_valid: 1'b0,
                                     best_ask: '1, ask_valid: 1'b0,
                                     last_price: '0},
                            exec_qty: '0};
            for (int s = 0; s < NUM_STOCKS; s++) begin
                cache_q[s] <= '{best_bid: '0, bid_valid: 1'b0,
                                best_ask: '1, ask_valid: 1'b0,
                                last_price: '0};
                for (int i = 0; i < BOOK_DEPTH; i++)
                    book_q[s][i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            free_idx_q <= free_idx_d;
            id_idx_q   <= id_idx_d;
            status_q   <= status_d;
            fill_q     <= fill_d;
            scan_idx_q <= scan_idx_d;
            scan_q     <= scan_d;
            res_q      <= res_d;
            cache_q    <= cache_d;
            book_q     <= book_d;
        end
    end

    assign bus.o_ready      = (state_q == S_IDLE) && !i_reset;
    assign bus.o_data_valid = (state_q == S_PUBLISH);
    assign bus.o_stock_id   = res_q.stock;
    assign bus.o_status     = res_q.status;
    assign bus.o_best_bid   = res_q.cache.best_bid;
    assign bus.o_bid_valid  = res_q.cache.bid_valid;
    assign bus.o_best_ask   = res_q.cache.best_ask;
    assign bus.o_ask_valid  = res_q.cache.ask_valid;
    assign bus.o_last_price = res_q.cache.last_price;
    assign bus.o_exec_qty   = res_q.exec_qty;

endmodule

// File: tb/tb_order_book_engine.sv
// Directed bench for order_book_engine: book updates, best-price rescan,
// error statuses, latency and reset in the middle of a command.
module tb_order_book_engine;
    import order_book_pkg::*;

    localparam int D     = 16;
    localparam int OK_L  = 3 + D;
    localparam int ERR_L = 2;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors = 0;
    int   lat;
    bit   seen;

    always #5 clk = ~clk;

    order_book_engine_if bus ();

    order_book_engine u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command; lat = cycles from acceptance edge to o_data_valid.
    task automatic cmd(input int sid, input int typ, input bit side,
                       input int qty, input int px, input int id,
                       output int l);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.i_stock_id   = 2'(sid);
        bus.i_order_type = 2'(typ);
        bus.i_side       = side;
        bus.i_quantity   = 16'(qty);
        bus.i_price      = 32'(px);
        bus.i_order_id   = 32'(id);
        bus.i_valid      = 1'b1;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        l = 0;
        while (l < 100) begin
            @(negedge clk);
            l++;
            if (bus.o_data_valid) break;
        end
    endtask

    task automatic res(input string tag, input int l, input int el,
                       input int sid, input status_t st,
                       input logic [31:0] bid, input bit bv,
                       input logic [31:0] ask, input bit av,
                       input logic [31:0] last, input int xq);
        chk({tag, "_lat"}, 64'(l), 64'(el));
        chk({tag, "_sid"}, 64'(bus.o_stock_id), 64'(sid));
        chk({tag, "_st"}, 64'(bus.o_status), 64'(st));
        chk({tag, "_bid"}, 64'(bus.o_best_bid), 64'(bid));
        chk({tag, "_bv"}, 64'(bus.o_bid_valid), 64'(bv));
        chk({tag, "_ask"}, 64'(bus.o_best_ask), 64'(ask));
        chk({tag, "_av"}, 64'(bus.o_ask_valid), 64'(av));
        chk({tag, "_last"}, 64'(bus.o_last_price), 64'(last));
        chk({tag, "_xq"}, 64'(bus.o_exec_qty), 64'(xq));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_dv"}, 64'(bus.o_data_valid), 64'd0);
        chk({tag, "_st"}, 64'(bus.o_status), 64'd0);
        chk({tag, "_sid"}, 64'(bus.o_stock_id), 64'd0);
        chk({tag, "_bid"}, 64'(bus.o_best_bid), 64'd0);
        chk({tag, "_bv"}, 64'(bus.o_bid_valid), 64'd0);
        chk({tag, "_ask"}, 64'(bus.o_best_ask), 64'(NONE));
        chk({tag, "_av"}, 64'(bus.o_ask_valid), 64'd0);
        chk({tag, "_last"}, 64'(bus.o_last_price), 64'd0);
        chk({tag, "_xq"}, 64'(bus.o_exec_qty), 64'd0);
    endtask

    initial begin
        bus.i_valid      = 1'b0;
        bus.i_stock_id   = '0;
        bus.i_order_type = '0;
        bus.i_side       = 1'b0;
        bus.i_quantity   = '0;
        bus.i_price      = '0;
        bus.i_order_id   = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.o_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
        reset_vals("rst");

        cmd(1, 0, 0, 5, 100, 10, lat);
        res("add_s1", lat, OK_L, 1, ST_OK, 100, 1, NONE, 0, 0, 0);
        @(negedge clk);
        chk("dv_pulse", 64'(bus.o_data_valid), 64'd0);
        chk("ready_back", 64'(bus.o_ready), 64'd1);
        chk("hold_bid", 64'(bus.o_best_bid), 64'd100);

        cmd(2, 0, 1, 4, 200, 1, lat);
        res("add_s2a", lat, OK_L, 2, ST_OK, 0, 0, 200, 1, 0, 0);
        cmd(2, 0, 1, 4, 190, 2, lat);
        res("add_s2b", lat, OK_L, 2, ST_OK, 0, 0, 190, 1, 0, 0);
        cmd(2, 1, 0, 1, 0, 2, lat);
        res("cxl_s2", lat, OK_L, 2, ST_OK, 0, 0, 200, 1, 0, 0);

        cmd(1, 2, 0, 3, 0, 10, lat);
        res("exe_part", lat, OK_L, 1, ST_OK, 100, 1, NONE, 0, 100, 3);
        cmd(1, 2, 0, 9, 0, 10, lat);
        res("exe_rest", lat, OK_L, 1, ST_OK, 0, 0, NONE, 0, 100, 2);

        cmd(3, 0, 0, 1, 50, 1, lat);
        cmd(3, 0, 0, 1, 50, 2, lat);
        cmd(3, 1, 0, 1, 0, 1, lat);
        res("eq_px", lat, OK_L, 3, ST_OK, 50, 1, NONE, 0, 0, 0);

        for (int i = 0; i < D; i++)
            cmd(0, 0, 0, 1, 10 + i, 100 + i, lat);
        res("fill_s0", lat, OK_L, 0, ST_OK, 10 + D - 1, 1, NONE, 0, 0, 0);
        cmd(0, 0, 1, 1, 5, 200, lat);
        res("full", lat, ERR_L, 0, ST_FULL, 10 + D - 1, 1, NONE, 0, 0, 0);
        cmd(0, 0, 1, 1, 5, 105, lat);
        res("dup", lat, ERR_L, 0, ST_DUP_ID, 10 + D - 1, 1, NONE, 0, 0, 0);
        cmd(0, 1, 0, 1, 0, 999, lat);
        res("nf", lat, ERR_L, 0, ST_NOT_FOUND, 10 + D - 1, 1, NONE, 0,
            0, 0);
        cmd(0, 3, 0, 1, 0, 100, lat);
        res("rsvd", lat, ERR_L, 0, ST_BAD_CMD, 10 + D - 1, 1, NONE, 0,
            0, 0);
        cmd(1, 0, 0, 0, 7, 77, lat);
        res("qty0", lat, ERR_L, 1, ST_BAD_CMD, 0, 0, NONE, 0, 100, 0);

        @(negedge clk);
        bus.i_stock_id   = 2'd1;
        bus.i_order_type = 2'd0;
        bus.i_side       = 1'b0;
        bus.i_quantity   = 16'd1;
        bus.i_price      = 32'd300;
        bus.i_order_id   = 32'd20;
        bus.i_valid      = 1'b1;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.o_data_valid) seen = 1'b1;
        end
        chk("midrst_no_dv", 64'(seen), 64'd0);
        reset_vals("midrst");

        cmd(1, 1, 0, 1, 0, 10, lat);
        res("post_cxl10", lat, ERR_L, 1, ST_NOT_FOUND, 0, 0, NONE, 0, 0, 0);
        cmd(1, 1, 0, 1, 0, 20, lat);
        res("post_cxl20", lat, ERR_L, 1, ST_NOT_FOUND, 0, 0, NONE, 0, 0, 0);
        cmd(0, 1, 0, 1, 0, 100, lat);
        res("post_cxl_s0", lat, ERR_L, 0, ST_NOT_FOUND, 0, 0, NONE, 0,
            0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
